mul_issue_ctrl: RTL and testbench



---
 rtl/neocore_pkg.sv | 22 ++
 rtl/mul_grant_arb.sv | 41 ++++
 rtl/mul_issue_ctrl.sv | 151 +++++++++++++++
 tb/tb_mul_issue_ctrl.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/neocore_pkg.sv
// Shared NeoCore types for the multiply issue controller.
package neocore_pkg;

    localparam int unsigned MUL_OP_W  = 16;
    localparam int unsigned MUL_REG_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WB_LO = 2'd2,
        WB_HI = 2'd3
    } mul_ctrl_state_t;

    typedef struct packed {
        logic [MUL_OP_W-1:0]  a;
        logic [MUL_OP_W-1:0]  b;
        logic                 is_signed;
        logic [MUL_REG_W-1:0] rd_lo;
        logic [MUL_REG_W-1:0] rd_hi;
    } mul_req_t;

endpackage

// File: rtl/mul_grant_arb.sv
// Two-way request grant for the shared multiplier.
// MUL_RR_ARB_EN defined: round-robin with a pointer register.
// MUL_RR_ARB_EN undefined: fixed priority, slot 0 wins, no pointer.
module mul_grant_arb (
`ifdef MUL_RR_ARB_EN
    input  logic clk,
    input  logic rst_n,
`endif
    input  logic en,
    input  logic valid0,
    input  logic valid1,
    output logic grant0_c,
    output logic grant1_c
);

`ifdef MUL_RR_ARB_EN
    logic ptr_q;

    // Pointer slot wins when both are valid.
    always_comb begin
        grant0_c = en & valid0 & (~valid1 | ~ptr_q);
        grant1_c = en & valid1 & (~valid0 |  ptr_q);
    end

    // After each grant the pointer moves away from the granted slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= 1'b0;
        end else if (grant0_c | grant1_c) begin
            ptr_q <= grant0_c;
        end
    end
`else
    // Slot 0 always has priority.
    always_comb begin
        grant0_c = en & valid0;
        grant1_c = en & valid1 & ~valid0;
    end
`endif

endmodule

// File: rtl/mul_issue_ctrl.sv
// Shares one multiply_unit between two issue slots and sequences the
// 32-bit product into low/high 16-bit register-file writes.
// Optional round-robin arbitration via MUL_RR_ARB_EN (see mul_grant_arb).
module mul_issue_ctrl
    import neocore_pkg::*;
#(
    parameter int unsigned REG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [15:0]      req0_a,
    input  logic [15:0]      req0_b,
    input  logic             req0_signed,
    input  logic [REG_W-1:0] req0_rd_lo,
    input  logic [REG_W-1:0] req0_rd_hi,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [15:0]      req1_a,
    input  logic [15:0]      req1_b,
    input  logic             req1_signed,
    input  logic [REG_W-1:0] req1_rd_lo,
    input  logic [REG_W-1:0] req1_rd_hi,
    output logic [15:0]      mul_a,
    output logic [15:0]      mul_b,
    output logic             mul_signed,
    input  logic [15:0]      mul_lo,
    input  logic [15:0]      mul_hi,
    output logic             wb_valid,
    input  logic             wb_ready,
    output logic [REG_W-1:0] wb_rd,
    output logic [15:0]      wb_data,
    output logic             wb_src,
    output logic             busy
);

    mul_ctrl_state_t state_q, state_d;
    mul_req_t        op_q, op_d;
    mul_req_t        req0_pkt, req1_pkt;
    logic            src_q, src_d;
    logic            busy_q, busy_d;
    logic            wb_valid_q, wb_valid_d;
    logic            wb_hi_q, wb_hi_d;
    logic [REG_W-1:0] wb_rd_q, wb_rd_d;
    logic            grant0, grant1;

    // Grant only while idle; ready is combinational from state and valids.
    mul_grant_arb u_arb (
`ifdef MUL_RR_ARB_EN
        .clk      (clk),
        .rst_n    (rst_n),
`endif
        .en       (state_q == IDLE),
        .valid0   (req0_valid),
        .valid1   (req1_valid),
        .grant0_c (grant0),
        .grant1_c (grant1)
    );

    // Pack each slot's request payload.
    always_comb begin
        req0_pkt.a         = req0_a;
        req0_pkt.b         = req0_b;
        req0_pkt.is_signed = req0_signed;
        req0_pkt.rd_lo     = MUL_REG_W'(req0_rd_lo);
        req0_pkt.rd_hi     = MUL_REG_W'(req0_rd_hi);
        req1_pkt.a         = req1_a;
        req1_pkt.b         = req1_b;
        req1_pkt.is_signed = req1_signed;
        req1_pkt.rd_lo     = MUL_REG_W'(req1_rd_lo);
        req1_pkt.rd_hi     = MUL_REG_W'(req1_rd_hi);
    end

    // Next state, operand latch and registered-output next values.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        src_d   = src_q;
        unique case (state_q)
            IDLE: begin
                if (grant0 | grant1) begin
                    state_d = ISSUE;
                    op_d    = grant1 ? req1_pkt : req0_pkt;
                    src_d   = grant1;
                end
            end
            ISSUE: begin
                // A shared destination only receives the high half.
                state_d = (op_q.rd_lo == op_q.rd_hi) ? WB_HI : WB_LO;
            end
            WB_LO: begin
                if (wb_ready) state_d = WB_HI;
            end
            WB_HI: begin
                if (wb_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d     = (state_d != IDLE);
        wb_valid_d = (state_d == WB_LO) || (state_d == WB_HI);
        wb_hi_d    = (state_d == WB_HI);
        wb_rd_d    = '0;
        if (state_d == WB_LO) begin
            wb_rd_d = REG_W'(op_d.rd_lo);
        end else if (state_d == WB_HI) begin
            wb_rd_d = REG_W'(op_d.rd_hi);
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            op_q       <= '0;
            src_q      <= 1'b0;
            busy_q     <= 1'b0;
            wb_valid_q <= 1'b0;
            wb_hi_q    <= 1'b0;
            wb_rd_q    <= '0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            src_q      <= src_d;
            busy_q     <= busy_d;
            wb_valid_q <= wb_valid_d;
            wb_hi_q    <= wb_hi_d;
            wb_rd_q    <= wb_rd_d;
        end
    end

    // Operands stay on the multiplier until the next accept, so the
    // product is read straight from it for the whole writeback phase.
    always_comb begin
        req0_ready = grant0;
        req1_ready = grant1;
        mul_a      = op_q.a;
        mul_b      = op_q.b;
        mul_signed = op_q.is_signed;
        wb_valid   = wb_valid_q;
        wb_rd      = wb_rd_q;
        wb_src     = src_q;
        busy       = busy_q;
        wb_data    = '0;
        if (wb_valid_q) begin
            wb_data = wb_hi_q ? mul_hi : mul_lo;
        end
    end

endmodule

// File: tb/tb_mul_issue_ctrl.sv
// Self-checking bench for mul_issue_ctrl with a stand-in multiply_unit.
module tb_mul_issue_ctrl;

    localparam int unsigned REG_W = 4;

    logic             clk;
    logic             rst_n;
    logic             req0_valid, req1_valid;
    logic             req0_ready, req1_ready;
    logic [15:0]      req0_a, req0_b, req1_a, req1_b;
    logic             req0_signed, req1_signed;
    logic [REG_W-1:0] req0_rd_lo, req0_rd_hi, req1_rd_lo, req1_rd_hi;
    logic [15:0]      mul_a, mul_b;
    logic             mul_signed;
    logic [15:0]      mul_lo, mul_hi;
    logic             wb_valid, wb_ready;
    logic [REG_W-1:0] wb_rd;
    logic [15:0]      wb_data;
    logic             wb_src;
    logic             busy;
    logic [31:0]      prod_q;

    int total;
    int bad;

    mul_issue_ctrl #(.REG_W(REG_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req0_valid  (req0_valid),
        .req0_ready  (req0_ready),
        .req0_a      (req0_a),
        .req0_b      (req0_b),
        .req0_signed (req0_signed),
        .req0_rd_lo  (req0_rd_lo),
        .req0_rd_hi  (req0_rd_hi),
        .req1_valid  (req1_valid),
        .req1_ready  (req1_ready),
        .req1_a      (req1_a),
        .req1_b      (req1_b),
        .req1_signed (req1_signed),
        .req1_rd_lo  (req1_rd_lo),
        .req1_rd_hi  (req1_rd_hi),
        .mul_a       (mul_a),
        .mul_b       (mul_b),
        .mul_signed  (mul_signed),
        .mul_lo      (mul_lo),
        .mul_hi      (mul_hi),
        .wb_valid    (wb_valid),
        .wb_ready    (wb_ready),
        .wb_rd       (wb_rd),
        .wb_data     (wb_data),
        .wb_src      (wb_src),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Arithmetic reference: full 32-bit product of two 16-bit operands.
    function automatic logic [31:0] ref_prod(input logic [15:0] a, input logic [15:0] b,
                                             input logic s);
        int sa;
        int sb;
        if (s) begin
            sa = int'($signed(a));
            sb = int'($signed(b));
            return 32'(sa * sb);
        end
        return {16'h0, a} * {16'h0, b};
    endfunction

    // Stand-in multiply_unit: one-cycle registered latency.
    always_ff @(posedge clk) prod_q <= ref_prod(mul_a, mul_b, mul_signed);
    assign mul_lo = prod_q[15:0];
    assign mul_hi = prod_q[31:16];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int slot, input logic [15:0] a, input logic [15:0] b,
                           input logic s, input logic [3:0] lo, input logic [3:0] hi);
        if (slot == 0) begin
            req0_valid = 1'b1; req0_a = a; req0_b = b; req0_signed = s;
            req0_rd_lo = lo; req0_rd_hi = hi;
        end else begin
            req1_valid = 1'b1; req1_a = a; req1_b = b; req1_signed = s;
            req1_rd_lo = lo; req1_rd_hi = hi;
        end
    endtask

    // Wait (bounded) for a handshake; returns granted slot or -1.
    task automatic wait_accept(output int slot);
        slot = -1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (req0_ready || req1_ready) begin
                chk("single_grant", 32'(req0_ready & req1_ready), 32'd0);
                slot = req1_ready ? 1 : 0;
                @(posedge clk);
                #1;
                return;
            end
        end
        total++;
        bad++;
        $error("FAIL accept_timeout observed=no_grant expected=grant");
    endtask

    // Checks the full writeback sequence; entered 1 time unit after the accept edge.
    task automatic expect_op(input int slot, input logic [15:0] a, input logic [15:0] b,
                             input logic s, input logic [3:0] lo, input logic [3:0] hi,
                             input int stall);
        logic [31:0] p;
        int          nw;
        logic [3:0]  erd;
        logic [15:0] edat;
        p  = ref_prod(a, b, s);
        nw = (lo == hi) ? 1 : 2;
        chk("issue_busy", 32'(busy), 32'd1);
        chk("issue_wb_valid", 32'(wb_valid), 32'd0);
        chk("no_ready_busy", 32'(req0_ready | req1_ready), 32'd0);
        chk("mul_a", 32'(mul_a), 32'(a));
        chk("mul_b", 32'(mul_b), 32'(b));
        chk("mul_signed", 32'(mul_signed), 32'(s));
        wb_ready = (stall == 0);
        for (int w = 0; w < nw; w++) begin
            @(posedge clk);
            #1;
            erd  = (w == nw - 1) ? hi : lo;
            edat = (w == nw - 1) ? p[31:16] : p[15:0];
            chk("wb_valid", 32'(wb_valid), 32'd1);
            chk("wb_rd", 32'(wb_rd), 32'(erd));
            chk("wb_data", 32'(wb_data), 32'(edat));
            chk("wb_src", 32'(wb_src), 32'(slot));
            if (w == 0) begin
                for (int k = 0; k < stall; k++) begin
                    @(posedge clk);
                    #1;
                    chk("stall_valid", 32'(wb_valid), 32'd1);
                    chk("stall_rd", 32'(wb_rd), 32'(erd));
                    chk("stall_data", 32'(wb_data), 32'(edat));
                    chk("stall_mul_a", 32'(mul_a), 32'(a));
                    chk("stall_mul_b", 32'(mul_b), 32'(b));
                end
                wb_ready = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        chk("done_busy", 32'(busy), 32'd0);
        chk("done_wb_valid", 32'(wb_valid), 32'd0);
    endtask

    task automatic run_op(input int slot, input logic [15:0] a, input logic [15:0] b,
                          input logic s, input logic [3:0] lo, input logic [3:0] hi,
                          input int stall);
        int g;
        set_req(slot, a, b, s, lo, hi);
        wait_accept(g);
        if (slot == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
        if (g >= 0) begin
            chk("grant_slot", 32'(g), 32'(slot));
            expect_op(slot, a, b, s, lo, hi, stall);
        end
    endtask

    initial begin
        int          g;
        int          exp_slot;
        int          slot;
        logic [15:0] ra, rb;
        logic        rs;
        logic [3:0]  rlo, rhi;

        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        wb_ready = 1'b1;
        req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_signed = 1'b0;
        req0_rd_lo = '0; req0_rd_hi = '0;
        req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_signed = 1'b0;
        req1_rd_lo = '0; req1_rd_hi = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_wb_valid", 32'(wb_valid), 32'd0);
        chk("rst_mul_a", 32'(mul_a), 32'd0);
        chk("rst_mul_b", 32'(mul_b), 32'd0);
        chk("rst_mul_signed", 32'(mul_signed), 32'd0);
        chk("rst_wb_rd", 32'(wb_rd), 32'd0);
        chk("rst_wb_data", 32'(wb_data), 32'd0);
        chk("rst_wb_src", 32'(wb_src), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single unsigned op: 5*7 -> (2,0x0023) then (3,0x0000)
        run_op(0, 16'd5, 16'd7, 1'b0, 4'd2, 4'd3, 0);
        // Signed op: -100*200 -> lo 0xB1E0, hi 0xFFFF
        run_op(1, 16'hFF9C, 16'd200, 1'b1, 4'd4, 4'd6, 0);
        // Max unsigned with a 3-cycle writeback stall in WB_LO
        run_op(0, 16'hFFFF, 16'hFFFF, 1'b0, 4'd8, 4'd9, 3);
        // Same destination: one write of the high half
        run_op(0, 16'd3, 16'd4, 1'b0, 4'd5, 4'd5, 0);

        // Reset asserted during WB_LO
        set_req(0, 16'h1234, 16'h0042, 1'b0, 4'd1, 4'd2);
        wait_accept(g);
        req0_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("pre_rst_wb_valid", 32'(wb_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst_wb_valid", 32'(wb_valid), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_mul_a", 32'(mul_a), 32'd0);
        chk("midrst_mul_b", 32'(mul_b), 32'd0);
        chk("midrst_wb_rd", 32'(wb_rd), 32'd0);
        chk("midrst_wb_data", 32'(wb_data), 32'd0);
        chk("midrst_wb_src", 32'(wb_src), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("midrst_hold_valid", 32'(wb_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_op(1, 16'd300, 16'd11, 1'b0, 4'd10, 4'd11, 0);

        // Contention: both slots valid continuously
        set_req(0, 16'd3, 16'd9, 1'b0, 4'd1, 4'd2);
        set_req(1, 16'd100, 16'd200, 1'b0, 4'd6, 4'd7);
        for (int k = 0; k < 4; k++) begin
`ifdef MUL_RR_ARB_EN
            exp_slot = k % 2;
`else
            exp_slot = 0;
`endif
            wait_accept(g);
            if (g < 0) break;
            chk("cont_grant", 32'(g), 32'(exp_slot));
            if (g == 0) expect_op(0, 16'd3, 16'd9, 1'b0, 4'd1, 4'd2, 0);
            else        expect_op(1, 16'd100, 16'd200, 1'b0, 4'd6, 4'd7, 0);
        end
        req0_valid = 1'b0;
        wait_accept(g);
        req1_valid = 1'b0;
        if (g >= 0) begin
            chk("cont_slot1_after_drop", 32'(g), 32'd1);
            expect_op(1, 16'd100, 16'd200, 1'b0, 4'd6, 4'd7, 0);
        end

        // Randomized single-slot ops against the arithmetic model
        for (int n = 0; n < 24; n++) begin
            slot = int'($urandom_range(0, 1));
            ra   = 16'($urandom);
            rb   = 16'($urandom);
            rs   = 1'($urandom);
            rlo  = 4'($urandom);
            rhi  = ($urandom_range(0, 3) == 0) ? rlo : 4'($urandom);
            run_op(slot, ra, rb, rs, rlo, rhi, int'($urandom_range(0, 2)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "time limit");
    end

endmodule
